// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    localparam int          PC_RESET     = 0;
    localparam logic [31:0] BUBBLE_INSTR = 32'h0;
    localparam int          PC_STEP      = 4;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: EX redirect, hazard/halt controls, instruction memory and IF/ID outputs.
interface fetch_if #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32,
    parameter int CNT_W = 16
) ();
    logic              PcSel;
    logic [31:0]       BrPC;
    logic              stall;
    logic              halt_req;
    logic [INS_W-1:0]  imem_rdata;
    logic [PC_W-1:0]   imem_addr;
    logic [PC_W-1:0]   ifid_pc;
    logic [INS_W-1:0]  ifid_instr;
    logic              ifid_valid;
    logic              halted;
    logic [CNT_W-1:0]  redirect_count;

    // The fetch stage itself
    modport master (
        input  PcSel, BrPC, stall, halt_req, imem_rdata,
        output imem_addr, ifid_pc, ifid_instr, ifid_valid, halted, redirect_count
    );

    // Surrounding pipeline and instruction memory
    modport slave (
        output PcSel, BrPC, stall, halt_req, imem_rdata,
        input  imem_addr, ifid_pc, ifid_instr, ifid_valid, halted, redirect_count
    );
endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register; bubble beats hold, hold beats capture.
module ifid_reg
    import fetch_pkg::*;
#(
    parameter int PC_W  = 9,
    parameter int INS_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_bubble,
    input  logic             i_hold,
    input  logic [PC_W-1:0]  i_pc,
    input  logic [INS_W-1:0] i_instr,
    output logic [PC_W-1:0]  o_pc,
    output logic [INS_W-1:0] o_instr,
    output logic             o_valid
);
    logic [PC_W-1:0]  r_pc;
    logic [INS_W-1:0] r_instr;
    logic             r_valid;

    always_ff @(posedge clk) begin
        if (reset || i_bubble) begin
            r_pc    <= '0;
            r_instr <= INS_W'(BUBBLE_INSTR);
            r_valid <= 1'b0;
        end else if (!i_hold) begin
            r_pc    <= i_pc;
            r_instr <= i_instr;
            r_valid <= 1'b1;
        end
    end

    assign o_pc    = r_pc;
    assign o_instr = r_instr;
    assign o_valid = r_valid;
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, RUN/HALTED FSM and redirect counter.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int PC_W  = 9,
    parameter int INS_W = 32,
    parameter int CNT_W = 16
) (
    input  logic   clk,
    input  logic   reset,
    fetch_if.master bus
);
    logic [PC_W-1:0]  r_pc;
    fetch_state_e     r_state;
    logic [CNT_W-1:0] r_count;

    logic [PC_W-1:0]  w_target;
    logic [PC_W-1:0]  w_pc_next;
    logic             w_freeze;
    logic             w_bubble;
    logic             w_unused_brpc;

    // Only the in-range word address of the target matters
    assign w_target      = {bus.BrPC[PC_W-1:2], 2'b00};
    assign w_unused_brpc = ^{bus.BrPC[31:PC_W], bus.BrPC[1:0]};

    // A pending or active halt freezes fetch unless an older redirect arrives
    assign w_freeze = (r_state == HALTED) || bus.halt_req;
    assign w_bubble = bus.PcSel || w_freeze;

    always_comb begin
        w_pc_next = r_pc + PC_W'(PC_STEP);
        if (bus.PcSel) begin
            w_pc_next = w_target;
        end else if (w_freeze || bus.stall) begin
            w_pc_next = r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= PC_W'(PC_RESET);
            r_state <= RUN;
            r_count <= '0;
        end else begin
            r_pc <= w_pc_next;
            if (bus.PcSel) begin
                r_state <= RUN;
            end else if (bus.halt_req) begin
                r_state <= HALTED;
            end
            if (bus.PcSel && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    ifid_reg #(
        .PC_W  (PC_W),
        .INS_W (INS_W)
    ) u_ifid (
        .clk      (clk),
        .reset    (reset),
        .i_bubble (w_bubble),
        .i_hold   (bus.stall),
        .i_pc     (r_pc),
        .i_instr  (bus.imem_rdata),
        .o_pc     (bus.ifid_pc),
        .o_instr  (bus.ifid_instr),
        .o_valid  (bus.ifid_valid)
    );

    assign bus.imem_addr      = r_pc;
    assign bus.halted         = (r_state == HALTED);
    assign bus.redirect_count = r_count;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a queue of expected post-edge states.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic reset;

    fetch_if #(.PC_W(9), .INS_W(32), .CNT_W(16)) bus ();

    fetch_stage #(.PC_W(9), .INS_W(32), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Instruction memory: data derived from address
    assign bus.imem_rdata = 32'hA500_0000 | {23'h0, bus.imem_addr};

    typedef struct packed {
        logic [8:0]  addr;
        logic [8:0]  ipc;
        logic [31:0] instr;
        logic        valid;
        logic        halted;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [31:0] ins(input logic [8:0] a);
        return 32'hA500_0000 | {23'h0, a};
    endfunction

    function automatic exp_t mk(input logic [8:0] addr, input logic [8:0] ipc,
                                input logic [31:0] instr, input logic valid,
                                input logic halted, input logic [15:0] cnt);
        exp_t e;
        e.addr = addr; e.ipc = ipc; e.instr = instr;
        e.valid = valid; e.halted = halted; e.cnt = cnt;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_pop(input int n);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL scoreboard_empty: observed=0 expected=1 (step %0d)", n);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("imem_addr",      32'(bus.imem_addr),      32'(e.addr));
            chk("ifid_pc",        32'(bus.ifid_pc),        32'(e.ipc));
            chk("ifid_instr",     bus.ifid_instr,          e.instr);
            chk("ifid_valid",     32'(bus.ifid_valid),     32'(e.valid));
            chk("halted",         32'(bus.halted),         32'(e.halted));
            chk("redirect_count", 32'(bus.redirect_count), 32'(e.cnt));
        end
    endtask

    int step_no = 0;

    task automatic step(input logic rst, input logic sel, input logic [31:0] br,
                        input logic stl, input logic hr, input exp_t e);
        reset        = rst;
        bus.PcSel    = sel;
        bus.BrPC     = br;
        bus.stall    = stl;
        bus.halt_req = hr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        $display("step %0d: rst=%0b sel=%0b br=%h stall=%0b halt_req=%0b -> addr=%h ifid_pc=%h instr=%h v=%0b halted=%0b cnt=%0d",
                 step_no, rst, sel, br, stl, hr, bus.imem_addr, bus.ifid_pc,
                 bus.ifid_instr, bus.ifid_valid, bus.halted, bus.redirect_count);
        compare_pop(step_no);
    endtask

    task automatic redirect_run(input int n);
        for (int i = 0; i < n; i++) begin
            reset = 1'b0; bus.PcSel = 1'b1; bus.BrPC = 32'h100;
            bus.stall = 1'b0; bus.halt_req = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; bus.PcSel = 1'b0; bus.BrPC = '0; bus.stall = 1'b0; bus.halt_req = 1'b0;
        #1;
        // Reset and free run
        step(1, 0, 0, 0, 0, mk(9'h000, 9'h000, 32'h0, 0, 0, 0));
        step(0, 0, 0, 0, 0, mk(9'h004, 9'h000, ins(9'h000), 1, 0, 0));
        step(0, 0, 0, 0, 0, mk(9'h008, 9'h004, ins(9'h004), 1, 0, 0));
        step(0, 0, 0, 0, 0, mk(9'h00C, 9'h008, ins(9'h008), 1, 0, 0));
        step(0, 0, 0, 0, 0, mk(9'h010, 9'h00C, ins(9'h00C), 1, 0, 0));
        // Redirect with misaligned target
        step(0, 1, 32'h0000_0143, 0, 0, mk(9'h140, 9'h000, 32'h0, 0, 0, 1));
        step(0, 0, 0, 0, 0, mk(9'h144, 9'h140, ins(9'h140), 1, 0, 1));
        // Reach pc=0x20 with a real instruction in IF/ID, then stall
        step(0, 1, 32'h18, 0, 0, mk(9'h018, 9'h000, 32'h0, 0, 0, 2));
        step(0, 0, 0, 0, 0, mk(9'h01C, 9'h018, ins(9'h018), 1, 0, 2));
        step(0, 0, 0, 0, 0, mk(9'h020, 9'h01C, ins(9'h01C), 1, 0, 2));
        step(0, 0, 0, 1, 0, mk(9'h020, 9'h01C, ins(9'h01C), 1, 0, 2));
        step(0, 0, 0, 1, 0, mk(9'h020, 9'h01C, ins(9'h01C), 1, 0, 2));
        step(0, 0, 0, 1, 0, mk(9'h020, 9'h01C, ins(9'h01C), 1, 0, 2));
        step(0, 1, 32'h80, 1, 0, mk(9'h080, 9'h000, 32'h0, 0, 0, 3));
        step(0, 0, 0, 0, 0, mk(9'h084, 9'h080, ins(9'h080), 1, 0, 3));
        // Halt at 0x30, resume by redirect
        step(0, 1, 32'h30, 0, 0, mk(9'h030, 9'h000, 32'h0, 0, 0, 4));
        step(0, 0, 0, 0, 1, mk(9'h030, 9'h000, 32'h0, 0, 1, 4));
        step(0, 0, 0, 0, 0, mk(9'h030, 9'h000, 32'h0, 0, 1, 4));
        step(0, 0, 0, 1, 0, mk(9'h030, 9'h000, 32'h0, 0, 1, 4));
        step(0, 1, 32'h40, 0, 0, mk(9'h040, 9'h000, 32'h0, 0, 0, 5));
        step(0, 0, 0, 0, 0, mk(9'h044, 9'h040, ins(9'h040), 1, 0, 5));
        // Simultaneous halt and redirect
        step(0, 1, 32'h50, 0, 1, mk(9'h050, 9'h000, 32'h0, 0, 0, 6));
        step(0, 0, 0, 0, 0, mk(9'h054, 9'h050, ins(9'h050), 1, 0, 6));
        // PC wrap
        step(0, 1, 32'h1F8, 0, 0, mk(9'h1F8, 9'h000, 32'h0, 0, 0, 7));
        step(0, 0, 0, 0, 0, mk(9'h1FC, 9'h1F8, ins(9'h1F8), 1, 0, 7));
        step(0, 0, 0, 0, 0, mk(9'h000, 9'h1FC, ins(9'h1FC), 1, 0, 7));
        step(0, 0, 0, 0, 0, mk(9'h004, 9'h000, ins(9'h000), 1, 0, 7));
        // Upper target bits ignored
        step(0, 1, 32'hFFFF_FE4B, 0, 0, mk(9'h048, 9'h000, 32'h0, 0, 0, 8));
        // Counter saturation
        redirect_run(65526);
        step(0, 1, 32'h100, 0, 0, mk(9'h100, 9'h000, 32'h0, 0, 0, 16'hFFFF));
        step(0, 1, 32'h100, 0, 0, mk(9'h100, 9'h000, 32'h0, 0, 0, 16'hFFFF));
        redirect_run(3);
        step(0, 1, 32'h100, 0, 0, mk(9'h100, 9'h000, 32'h0, 0, 0, 16'hFFFF));
        step(0, 0, 0, 0, 0, mk(9'h104, 9'h100, ins(9'h100), 1, 0, 16'hFFFF));
        // Reset while halted, with stall and redirect asserted
        step(0, 0, 0, 0, 1, mk(9'h104, 9'h000, 32'h0, 0, 1, 16'hFFFF));
        step(1, 1, 32'h80, 1, 1, mk(9'h000, 9'h000, 32'h0, 0, 0, 0));
        step(0, 0, 0, 0, 0, mk(9'h004, 9'h000, ins(9'h000), 1, 0, 0));

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage: owns the program counter and the IF/ID pipeline register.
- Consumes the taken-branch redirect (PcSel, BrPC) from the EX-stage branch unit and the halt request from decode.
- Drives the instruction-memory address and presents {pc, instr, valid} to decode.
- Sits directly upstream of decode and closes the redirect loop from EX.

Parameters:
- PC_W, 9, PC and instruction-memory address width in bits (byte address).
- INS_W, 32, instruction width.
- CNT_W, 16, width of the redirect performance counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- PcSel  in  1  branch/jump taken in EX this cycle.
- BrPC  in  32  redirect target from EX; valid when PcSel=1.
- stall  in  1  hazard-unit freeze of PC and IF/ID (load-use).
- halt_req  in  1  decode has a halt instruction in IF/ID.
- imem_rdata  in  INS_W  instruction read combinationally at imem_addr.
- imem_addr  out  PC_W  current fetch PC (= pc register).
- ifid_pc  out  PC_W  PC of the instruction held in IF/ID.
- ifid_instr  out  INS_W  instruction held in IF/ID.
- ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- halted  out  1  fetch is frozen in HALTED.
- redirect_count  out  CNT_W  number of taken redirects, saturating.

Behaviour:
- Reset (sampled at posedge): pc=0, ifid_pc=0, ifid_instr=0, ifid_valid=0, state=RUN, halted=0, redirect_count=0.
- FSM has two states: RUN and HALTED.
  - RUN -> HALTED when halt_req=1 and PcSel=0.
  - HALTED -> RUN on PcSel=1 (an older control transfer overrides the speculative halt).
  - HALTED otherwise holds until reset.
  - halted = (state==HALTED).
- Next-PC priority, highest first:
  1. reset -> 0.
  2. PcSel -> {BrPC[PC_W-1:2], 2'b00}. Upper bits of BrPC are ignored; low two bits are forced to 0.
  3. HALTED, or RUN with halt_req=1 -> hold pc.
  4. stall -> hold pc.
  5. Otherwise pc + 4, wrapping modulo 2^PC_W (e.g. 0x1FC -> 0x000).
- PcSel overrides stall: a redirect is never lost to a concurrent freeze.
- IF/ID update, same priority order:
  - PcSel -> bubble: ifid_valid=0, ifid_instr=0, ifid_pc=0.
  - halt_req in RUN, or HALTED -> bubble.
  - stall -> hold all IF/ID fields.
  - Else capture ifid_pc=pc, ifid_instr=imem_rdata, ifid_valid=1.
- Latency:
  - Instruction fetched at pc in cycle n appears on the ifid_* outputs in cycle n+1.
  - PcSel in cycle n gives pc=target and a bubble in IF/ID in cycle n+1; the target instruction appears in IF/ID in cycle n+2.
  - Redirect penalty inside this block is therefore 1 bubble.
- Simultaneous halt_req and PcSel: PcSel wins, halt is discarded, state stays RUN.
- redirect_count: +1 on every cycle with PcSel=1 (in either state); saturates at 2^CNT_W-1; cleared only by reset.
- Reset mid-operation (any state, any stall) returns all outputs to their reset values at the next edge; no partial update.
- All outputs are registered; no combinational path from PcSel/BrPC to any output.

Decomposition:
- Shared package fetch_pkg:
  - enum fetch_state_e {RUN, HALTED}.
  - PC_RESET = 0.
  - BUBBLE_INSTR = 32'h0.
  - PC_STEP = 4.
- One natural sub-module, ifid_reg: holds the {pc, instr, valid} register with hold and bubble controls.
- PC register, next-PC mux and FSM stay in fetch_stage.

Test Plan:
- Reset, then 4 free-run cycles with imem_rdata=addr-derived data -> imem_addr 0,4,8,C; ifid_pc trails by 1 cycle, ifid_valid=1 from cycle 2.
- At pc=0x10, PcSel=1, BrPC=0x0000_0143 -> next pc=0x140, IF/ID bubble (valid=0, instr=0); cycle after: ifid_pc=0x140, valid=1; redirect_count=1.
- stall=1 for 3 cycles at pc=0x20 -> imem_addr and IF/ID frozen; assert PcSel, BrPC=0x80 during the stall -> pc=0x80 next cycle and IF/ID bubble.
- halt_req=1 at pc=0x30 -> halted=1 next cycle, pc held at 0x30, ifid_valid=0 thereafter; later PcSel, BrPC=0x40 -> RUN, pc=0x40.
- halt_req=1 and PcSel=1 with BrPC=0x50 in the same cycle -> halted stays 0, pc=0x50.
- Free-run from pc=0x1F8 -> 0x1FC then 0x000; drive PcSel for 2^CNT_W+3 cycles -> redirect_count=0xFFFF; reset mid-HALTED -> all outputs return to their reset values at the next edge.
